pong_game_ctrl: RTL and testbench

- Match sequencer for the Pong datapath. Sits between the reset/lock generator and the ball/paddle logic.
- Decides when the ball may move (gmv), when it is re-centred (ball_rst) and which way it is served.
- Counts points from the lossA/lossB miss indications and declares a winner.
- All timing is in video frames, counted from a one-cycle frame_tick strobe.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_game_ctrl_if.sv | 40 ++++
 rtl/pong_game_ctrl_frame_timer.sv | 41 ++++
 rtl/pong_game_ctrl.sv | 144 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pong_pkg
// Purpose : Shared types and constants for the Pong match sequencer.
//           - state_t        : match sequencer states
//           - DIR_A / DIR_B  : serve direction encodings
//           - SCORE_W_DEFAULT: default score counter width
// Revision: 1.0 - initial release
// ============================================================================
package pong_pkg;

  localparam int SCORE_W_DEFAULT = 4;

  // Serve direction: the ball is served toward the player who lost the point.
  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl_if
// Purpose : Bundles the match sequencer's control inputs and status outputs.
// Ports   : frame_tick, start, lossA, lossB   (environment -> sequencer)
//           gmv, ball_rst, serve_dir, score_a, score_b, game_over, winner
//                                             (sequencer -> environment)
// Modports: master - environment side (drives frame_tick/start/loss levels)
//           slave  - sequencer side (pong_game_ctrl)
// Revision: 1.0 - initial release
// ============================================================================
interface pong_game_ctrl_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEFAULT
);
  logic               frame_tick;
  logic               start;
  logic               lossA;
  logic               lossB;
  logic               gmv;
  logic               ball_rst;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               game_over;
  logic               winner;

  modport master (
    output frame_tick, start, lossA, lossB,
    input  gmv, ball_rst, serve_dir, score_a, score_b, game_over, winner
  );

  modport slave (
    input  frame_tick, start, lossA, lossB,
    output gmv, ball_rst, serve_dir, score_a, score_b, game_over, winner
  );

endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module  : frame_timer
// Purpose : Loadable frame down-counter shared by the SERVE and POINT phases.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           load       - load load_val (wins over tick)
//           load_val   - frame count to load
//           tick       - one-cycle frame strobe, decrements the count
//           done       - high on the tick cycle where the count is 1
// Revision: 1.0 - initial release
// ============================================================================
module frame_timer
  import pong_pkg::*;
#(
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [FCNT_W-1:0] load_val,
  input  logic              tick,
  output logic              done
);

  logic [FCNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Expiry coincides with the final tick so a load-count of N spans N ticks.
  assign done = tick && (count == FCNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl
// Purpose : Pong match sequencer. Gates ball motion, re-centres the ball,
//           chooses the serve direction, keeps score and declares a winner.
//           All delays are counted in video frames.
// Ports   : clk, rst - clock, synchronous active-high reset
//           bus      - pong_game_ctrl_if.slave (frame_tick, start, lossA,
//                      lossB in; gmv, ball_rst, serve_dir, score_a, score_b,
//                      game_over, winner out)
// Revision: 1.0 - initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = SCORE_W_DEFAULT,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 90,
  parameter int FCNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);

  localparam logic [FCNT_W-1:0]  SERVE_LOAD = FCNT_W'(SERVE_FRAMES);
  localparam logic [FCNT_W-1:0]  HOLD_LOAD  = FCNT_W'(HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             state, state_n;
  logic [SCORE_W-1:0] score_a, score_a_n;
  logic [SCORE_W-1:0] score_b, score_b_n;
  logic               serve_dir, serve_dir_n;
  logic               winner, winner_n;

  logic               tmr_load;
  logic [FCNT_W-1:0]  tmr_val;
  logic               tmr_tick;
  logic               tmr_done;

  // Ticks only matter while a countdown is running.
  assign tmr_tick = bus.frame_tick && ((state == SERVE) || (state == POINT));

  frame_timer #(
    .FCNT_W (FCNT_W)
  ) u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .done     (tmr_done)
  );

  always_comb begin
    state_n     = state;
    score_a_n   = score_a;
    score_b_n   = score_b;
    serve_dir_n = serve_dir;
    winner_n    = winner;
    tmr_load    = 1'b0;
    tmr_val     = SERVE_LOAD;

    unique case (state)
      IDLE, OVER: begin
        // A new match keeps serve_dir so the last loser serves first.
        if (bus.start) begin
          state_n   = SERVE;
          score_a_n = '0;
          score_b_n = '0;
          tmr_load  = 1'b1;
          tmr_val   = SERVE_LOAD;
        end
      end

      SERVE: begin
        if (tmr_done) begin
          state_n = PLAY;
        end
      end

      PLAY: begin
        // Only the first loss cycle counts; PLAY is left immediately.
        if (bus.lossA || bus.lossB) begin
          if (bus.lossA && !bus.lossB) begin
            score_b_n   = score_b + 1'b1;
            serve_dir_n = DIR_A;
          end else if (bus.lossB && !bus.lossA) begin
            score_a_n   = score_a + 1'b1;
            serve_dir_n = DIR_B;
          end
          state_n  = POINT;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end
      end

      POINT: begin
        if (tmr_done) begin
          if ((score_a == WIN_VAL) || (score_b == WIN_VAL)) begin
            state_n  = OVER;
            winner_n = (score_b == WIN_VAL);
          end else begin
            state_n  = SERVE;
            tmr_load = 1'b1;
            tmr_val  = SERVE_LOAD;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      score_a   <= '0;
      score_b   <= '0;
      serve_dir <= DIR_A;
      winner    <= 1'b0;
    end else begin
      state     <= state_n;
      score_a   <= score_a_n;
      score_b   <= score_b_n;
      serve_dir <= serve_dir_n;
      winner    <= winner_n;
    end
  end

  // Outputs decode registered state only.
  assign bus.gmv       = (state == PLAY);
  assign bus.ball_rst  = (state != PLAY);
  assign bus.game_over = (state == OVER);
  assign bus.score_a   = score_a;
  assign bus.score_b   = score_b;
  assign bus.serve_dir = serve_dir;
  assign bus.winner    = winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pong_game_ctrl
// Purpose : Self-checking bench for pong_game_ctrl with randomized frame
//           spacing, ignored-input noise and random point outcomes, checked
//           against a score/phase model of the match rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int SW  = 4;
  localparam int WIN = 3;
  localparam int SRV = 2;
  localparam int HLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

  pong_game_ctrl #(
    .SCORE_W      (SW),
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SRV),
    .HOLD_FRAMES  (HLD),
    .FCNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_a       = 0;
  int   exp_b       = 0;
  logic exp_dir     = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  // Issues randomly spaced one-cycle frame ticks until gmv (which=0) or
  // game_over (which=1) rises. n = ticks issued, -2 if it rose on a non-tick
  // cycle, -1 if it never rose within the budget.
  task automatic tick_until(input int which, input int max_ticks, input bit noise, output int n);
    int cnt = 0;
    int cyc = 0;
    bit t   = 1'b0;
    bit hit = 1'b0;
    n = -1;
    while (!hit && cnt <= max_ticks && cyc < 400) begin
      t = t ? 1'b0 : ($urandom_range(0, 2) == 0);
      bus.frame_tick = t;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.lossA = 1'($urandom_range(0, 1));
        bus.lossB = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
      if (t) cnt++;
      if ((which == 0 && bus.gmv === 1'b1) || (which == 1 && bus.game_over === 1'b1)) begin
        hit = 1'b1;
        n   = t ? cnt : -2;
      end
    end
    bus.frame_tick = 1'b0;
    if (noise) begin
      bus.start = 1'b0;
      bus.lossA = 1'b0;
      bus.lossB = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (bus.gmv !== 1'b0)       begin miscompares++; $display("FAIL reset_gmv: got %b want 0", bus.gmv); end
    vectors++; if (bus.ball_rst !== 1'b1)  begin miscompares++; $display("FAIL reset_ball_rst: got %b want 1", bus.ball_rst); end
    vectors++; if (bus.score_a !== 4'd0 || bus.score_b !== 4'd0) begin miscompares++; $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.score_a, bus.score_b); end
    vectors++; if (bus.serve_dir !== 1'b0 || bus.winner !== 1'b0 || bus.game_over !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got dir=%b win=%b over=%b want 0/0/0", bus.serve_dir, bus.winner, bus.game_over); end
    rst = 1'b0;
    repeat (3) tick_once();
    vectors++; if (bus.gmv !== 1'b0 || bus.ball_rst !== 1'b1) begin miscompares++; $display("FAIL idle_hold: got gmv=%b ball_rst=%b want 0/1", bus.gmv, bus.ball_rst); end
  endtask

  task automatic test_serve();
    int n;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++; if (bus.gmv !== 1'b0 || bus.ball_rst !== 1'b1) begin miscompares++; $display("FAIL serve_outputs: got gmv=%b ball_rst=%b want 0/1", bus.gmv, bus.ball_rst); end
    vectors++; if (bus.score_a !== 4'd0 || bus.score_b !== 4'd0) begin miscompares++; $display("FAIL serve_scores: got %0d/%0d want 0/0", bus.score_a, bus.score_b); end
    tick_until(0, SRV + 2, 1'b1, n);
    vectors++; if (n !== SRV) begin miscompares++; $display("FAIL serve_ticks: got %0d want %0d", n, SRV); end
    vectors++; if (bus.ball_rst !== 1'b0) begin miscompares++; $display("FAIL play_ball_rst: got %b want 0", bus.ball_rst); end
  endtask

  task automatic test_loss_a_held();
    int n;
    repeat ($urandom_range(1, 5)) step();
    bus.lossA = 1'b1;
    step();
    exp_b++;
    exp_dir = DIR_A;
    vectors++; if (bus.gmv !== 1'b0) begin miscompares++; $display("FAIL lossA_gmv: got %b want 0", bus.gmv); end
    vectors++; if (bus.score_b !== 4'(exp_b) || bus.score_a !== 4'(exp_a)) begin miscompares++; $display("FAIL lossA_score: got %0d/%0d want %0d/%0d", bus.score_a, bus.score_b, exp_a, exp_b); end
    vectors++; if (bus.serve_dir !== exp_dir) begin miscompares++; $display("FAIL lossA_dir: got %b want %b", bus.serve_dir, exp_dir); end
    // lossA stays high through the hold and serve phases.
    tick_until(0, HLD + SRV + 2, 1'b0, n);
    bus.lossA = 1'b0;
    vectors++; if (n !== HLD + SRV) begin miscompares++; $display("FAIL lossA_resume_ticks: got %0d want %0d", n, HLD + SRV); end
    vectors++; if (bus.score_b !== 4'(exp_b) || bus.score_a !== 4'(exp_a)) begin miscompares++; $display("FAIL lossA_held_score: got %0d/%0d want %0d/%0d", bus.score_a, bus.score_b, exp_a, exp_b); end
  endtask

  task automatic test_both_loss();
    int n;
    repeat ($urandom_range(0, 4)) step();
    bus.lossA = 1'b1;
    bus.lossB = 1'b1;
    step();
    bus.lossA = 1'b0;
    bus.lossB = 1'b0;
    vectors++; if (bus.gmv !== 1'b0) begin miscompares++; $display("FAIL both_gmv: got %b want 0", bus.gmv); end
    vectors++; if (bus.score_a !== 4'(exp_a) || bus.score_b !== 4'(exp_b)) begin miscompares++; $display("FAIL both_score: got %0d/%0d want %0d/%0d", bus.score_a, bus.score_b, exp_a, exp_b); end
    vectors++; if (bus.serve_dir !== exp_dir) begin miscompares++; $display("FAIL both_dir: got %b want %b", bus.serve_dir, exp_dir); end
    tick_until(0, HLD + SRV + 2, 1'b1, n);
    vectors++; if (n !== HLD + SRV) begin miscompares++; $display("FAIL both_resume_ticks: got %0d want %0d", n, HLD + SRV); end
  endtask

  // Plays random points from PLAY until a player reaches WIN.
  // With only_a set, B is never allowed to reach the winning score.
  task automatic test_match(input bit only_a);
    int n;
    int pick;
    int guard = 0;
    while (exp_a < WIN && exp_b < WIN && guard < 40) begin
      guard++;
      repeat ($urandom_range(0, 4)) begin
        step();
        vectors++; if (bus.gmv !== 1'b1) begin miscompares++; $display("FAIL match_play_gmv: got %b want 1", bus.gmv); end
      end
      pick = $urandom_range(0, 2);
      if (guard > 20) pick = 1;
      if (only_a && pick == 0 && exp_b == WIN - 1) pick = 1;
      if (pick == 0)      begin bus.lossA = 1'b1; exp_b++; exp_dir = DIR_A; end
      else if (pick == 1) begin bus.lossB = 1'b1; exp_a++; exp_dir = DIR_B; end
      else                begin bus.lossA = 1'b1; bus.lossB = 1'b1; end
      step();
      bus.lossA = 1'b0;
      bus.lossB = 1'b0;
      vectors++; if (bus.score_a !== 4'(exp_a) || bus.score_b !== 4'(exp_b) || bus.serve_dir !== exp_dir || bus.gmv !== 1'b0)
        begin miscompares++; $display("FAIL match_point: got %0d/%0d dir=%b gmv=%b want %0d/%0d dir=%b gmv=0", bus.score_a, bus.score_b, bus.serve_dir, bus.gmv, exp_a, exp_b, exp_dir); end
      if (exp_a == WIN || exp_b == WIN) begin
        tick_until(1, HLD + 2, 1'b1, n);
        vectors++; if (n !== HLD) begin miscompares++; $display("FAIL match_over_ticks: got %0d want %0d", n, HLD); end
        vectors++; if (bus.winner !== logic'(exp_b == WIN)) begin miscompares++; $display("FAIL match_winner: got %b want %b", bus.winner, (exp_b == WIN)); end
        vectors++; if (bus.gmv !== 1'b0 || bus.ball_rst !== 1'b1) begin miscompares++; $display("FAIL over_outputs: got gmv=%b ball_rst=%b want 0/1", bus.gmv, bus.ball_rst); end
      end else begin
        tick_until(0, HLD + SRV + 2, 1'b1, n);
        vectors++; if (n !== HLD + SRV) begin miscompares++; $display("FAIL match_resume_ticks: got %0d want %0d", n, HLD + SRV); end
      end
    end
  endtask

  task automatic test_over_loss();
    bus.lossA = 1'b1;
    repeat (4) tick_once();
    bus.lossA = 1'b0;
    vectors++; if (bus.score_b !== 4'(exp_b) || bus.score_a !== 4'(exp_a)) begin miscompares++; $display("FAIL over_loss_score: got %0d/%0d want %0d/%0d", bus.score_a, bus.score_b, exp_a, exp_b); end
    vectors++; if (bus.game_over !== 1'b1 || bus.winner !== logic'(exp_b == WIN)) begin miscompares++; $display("FAIL over_hold: got over=%b win=%b want 1/%b", bus.game_over, bus.winner, (exp_b == WIN)); end
  endtask

  task automatic test_restart();
    int n;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_a = 0;
    exp_b = 0;
    vectors++; if (bus.game_over !== 1'b0 || bus.score_a !== 4'd0 || bus.score_b !== 4'd0) begin miscompares++; $display("FAIL restart_clear: got over=%b %0d/%0d want 0 0/0", bus.game_over, bus.score_a, bus.score_b); end
    vectors++; if (bus.serve_dir !== exp_dir) begin miscompares++; $display("FAIL restart_dir: got %b want %b", bus.serve_dir, exp_dir); end
    tick_until(0, SRV + 2, 1'b1, n);
    vectors++; if (n !== SRV) begin miscompares++; $display("FAIL restart_serve_ticks: got %0d want %0d", n, SRV); end
  endtask

  task automatic test_rst_mid_point();
    bus.lossB = 1'b1;
    step();
    bus.lossB = 1'b0;
    vectors++; if (bus.score_a !== 4'(exp_a + 1)) begin miscompares++; $display("FAIL pre_rst_score: got %0d want %0d", bus.score_a, exp_a + 1); end
    tick_once();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_a = 0; exp_b = 0; exp_dir = DIR_A;
    vectors++; if (bus.gmv !== 1'b0 || bus.ball_rst !== 1'b1 || bus.game_over !== 1'b0) begin miscompares++; $display("FAIL rst_point_outputs: got gmv=%b ball_rst=%b over=%b want 0/1/0", bus.gmv, bus.ball_rst, bus.game_over); end
    vectors++; if (bus.score_a !== 4'd0 || bus.score_b !== 4'd0 || bus.serve_dir !== 1'b0) begin miscompares++; $display("FAIL rst_point_state: got %0d/%0d dir=%b want 0/0 dir=0", bus.score_a, bus.score_b, bus.serve_dir); end
    repeat (HLD + SRV + 1) tick_once();
    vectors++; if (bus.gmv !== 1'b0) begin miscompares++; $display("FAIL rst_point_idle: got gmv=%b want 0", bus.gmv); end
  endtask

  task automatic test_rst_mid_serve();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tick_once();
    // Final serve tick and reset together: reset must win.
    bus.frame_tick = 1'b1;
    rst = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    vectors++; if (bus.gmv !== 1'b0 || bus.ball_rst !== 1'b1) begin miscompares++; $display("FAIL rst_serve_outputs: got gmv=%b ball_rst=%b want 0/1", bus.gmv, bus.ball_rst); end
    vectors++; if (bus.score_a !== 4'd0 || bus.score_b !== 4'd0) begin miscompares++; $display("FAIL rst_serve_scores: got %0d/%0d want 0/0", bus.score_a, bus.score_b); end
    rst = 1'b0;
    step();
    vectors++; if (bus.gmv !== 1'b0) begin miscompares++; $display("FAIL rst_serve_after: got gmv=%b want 0", bus.gmv); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.lossA      = 1'b0;
    bus.lossB      = 1'b0;
    test_reset();
    test_serve();
    test_loss_a_held();
    test_both_loss();
    test_match(1'b1);
    test_over_loss();
    test_restart();
    test_match(1'b0);
    test_restart();
    test_rst_mid_point();
    test_rst_mid_serve();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
